// File: rtl/layer_exec_controller.sv
// Layer execution controller: runs compute, issues credit-limited pointer walks, drains
// responses, and grants config flips only when the core is idle with nothing in flight.
package flexpipe_pkg;
    localparam int EPOCH_WIDTH = 8;

    typedef struct packed {
        logic [31:0]            compute_cycles;
        logic [31:0]            pointer_walks;
        logic [EPOCH_WIDTH-1:0] epoch;
    } layer_config_t;
endpackage

module layer_exec_controller
    import flexpipe_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8,
    parameter int STALE_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  layer_config_t              active_config,
    input  logic                       layer_start_pulse,
    input  logic                       request_flip,
    output logic                       flip_ack,
    output logic                       core_safe_to_flip,
    output logic                       no_outstanding_active,
    output logic                       walk_req_valid,
    input  logic                       walk_req_ready,
    output logic [31:0]                walk_req_idx,
    output logic [EPOCH_WIDTH-1:0]     walk_req_epoch,
    input  logic                       walk_rsp_valid,
    input  logic [EPOCH_WIDTH-1:0]     walk_rsp_epoch,
    output logic                       layer_done,
    output logic                       busy,
    output logic [STALE_CNT_WIDTH-1:0] stale_rsp_count,
    output logic                       protocol_err
);

    localparam int OCW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OCW-1:0] OUT_MAX  = OCW'(MAX_OUTSTANDING);
    localparam logic [OCW-1:0] OUT_ONE  = OCW'(1);
    localparam logic [OCW-1:0] OUT_ZERO = OCW'(0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        COMPUTE = 3'd2,
        WALK    = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t                     state_r, state_next_s;
    logic [31:0]                comp_cnt_r, comp_cnt_next_s;
    logic [31:0]                issued_r, issued_next_s;
    logic [31:0]                walks_r, walks_next_s;
    logic [EPOCH_WIDTH-1:0]     epoch_r, epoch_next_s;
    logic [OCW-1:0]             outstanding_r, outstanding_next_s;
    logic                       flip_ack_r, flip_ack_next_s;
    logic                       layer_done_r, layer_done_next_s;
    logic [STALE_CNT_WIDTH-1:0] stale_r, stale_next_s;
    logic                       perr_r, perr_next_s;
    logic                       fire_s, epoch_hit_s, rsp_match_s;

    assign walk_req_valid        = (state_r == WALK) && (issued_r < walks_r) && (outstanding_r < OUT_MAX);
    assign fire_s                = walk_req_valid && walk_req_ready;
    assign epoch_hit_s           = walk_rsp_valid && (walk_rsp_epoch == epoch_r);
    assign rsp_match_s           = epoch_hit_s && (outstanding_r != OUT_ZERO);
    assign walk_req_idx          = issued_r;
    assign walk_req_epoch        = epoch_r;
    assign flip_ack              = flip_ack_r;
    assign layer_done            = layer_done_r;
    assign core_safe_to_flip     = (state_r == IDLE);
    assign busy                  = (state_r != IDLE);
    assign no_outstanding_active = (outstanding_r == OUT_ZERO);
    assign stale_rsp_count       = stale_r;
    assign protocol_err          = perr_r;

    // Next-state and counter update logic
    always_comb begin
        state_next_s      = state_r;
        comp_cnt_next_s   = comp_cnt_r;
        issued_next_s     = issued_r;
        walks_next_s      = walks_r;
        epoch_next_s      = epoch_r;
        flip_ack_next_s   = 1'b0;
        layer_done_next_s = 1'b0;
        stale_next_s      = stale_r;
        perr_next_s       = perr_r;

        case ({fire_s, rsp_match_s})
            2'b10:   outstanding_next_s = outstanding_r + OUT_ONE;
            2'b01:   outstanding_next_s = outstanding_r - OUT_ONE;
            default: outstanding_next_s = outstanding_r;
        endcase

        if (walk_rsp_valid && !rsp_match_s && (stale_r != {STALE_CNT_WIDTH{1'b1}})) begin
            stale_next_s = stale_r + {{(STALE_CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            stale_next_s = stale_r;
        end

        // A start outside ARMED or a response nobody is waiting for is a protocol violation
        if ((layer_start_pulse && (state_r != ARMED)) || (epoch_hit_s && (outstanding_r == OUT_ZERO))) begin
            perr_next_s = 1'b1;
        end else begin
            perr_next_s = perr_r;
        end

        case (state_r)
            IDLE: begin
                if (request_flip && !flip_ack_r && (outstanding_r == OUT_ZERO)) begin
                    flip_ack_next_s = 1'b1;
                    state_next_s    = ARMED;
                end else begin
                    state_next_s    = IDLE;
                end
            end
            ARMED: begin
                if (layer_start_pulse) begin
                    comp_cnt_next_s = active_config.compute_cycles;
                    walks_next_s    = active_config.pointer_walks;
                    epoch_next_s    = active_config.epoch;
                    issued_next_s   = 32'd0;
                    if (active_config.compute_cycles != 32'd0) begin
                        state_next_s = COMPUTE;
                    end else if (active_config.pointer_walks != 32'd0) begin
                        state_next_s = WALK;
                    end else begin
                        state_next_s = DRAIN;
                    end
                end else begin
                    state_next_s = ARMED;
                end
            end
            COMPUTE: begin
                comp_cnt_next_s = comp_cnt_r - 32'd1;
                if (comp_cnt_r <= 32'd1) begin
                    state_next_s = (walks_r != 32'd0) ? WALK : DRAIN;
                end else begin
                    state_next_s = COMPUTE;
                end
            end
            WALK: begin
                // issued < walks whenever a fire happens, so issued+1 cannot wrap
                if (fire_s) begin
                    issued_next_s = issued_r + 32'd1;
                    if ((issued_r + 32'd1) == walks_r) begin
                        state_next_s = DRAIN;
                    end else begin
                        state_next_s = WALK;
                    end
                end else begin
                    state_next_s = WALK;
                end
            end
            DRAIN: begin
                if (outstanding_next_s == OUT_ZERO) begin
                    layer_done_next_s = 1'b1;
                    state_next_s      = IDLE;
                end else begin
                    state_next_s      = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            comp_cnt_r    <= 32'd0;
            issued_r      <= 32'd0;
            walks_r       <= 32'd0;
            epoch_r       <= {EPOCH_WIDTH{1'b0}};
            outstanding_r <= OUT_ZERO;
            flip_ack_r    <= 1'b0;
            layer_done_r  <= 1'b0;
            stale_r       <= {STALE_CNT_WIDTH{1'b0}};
            perr_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            comp_cnt_r    <= comp_cnt_next_s;
            issued_r      <= issued_next_s;
            walks_r       <= walks_next_s;
            epoch_r       <= epoch_next_s;
            outstanding_r <= outstanding_next_s;
            flip_ack_r    <= flip_ack_next_s;
            layer_done_r  <= layer_done_next_s;
            stale_r       <= stale_next_s;
            perr_r        <= perr_next_s;
        end
    end

endmodule

// File: tb/tb_layer_exec_controller.sv
// Directed self-checking bench for layer_exec_controller with hand-computed expectations.
module tb_layer_exec_controller;
    import flexpipe_pkg::*;

    logic                   clk;
    logic                   rst_n;
    layer_config_t          active_config;
    logic                   layer_start_pulse;
    logic                   request_flip;
    logic                   flip_ack;
    logic                   core_safe_to_flip;
    logic                   no_outstanding_active;
    logic                   walk_req_valid;
    logic                   walk_req_ready;
    logic [31:0]            walk_req_idx;
    logic [EPOCH_WIDTH-1:0] walk_req_epoch;
    logic                   walk_rsp_valid;
    logic [EPOCH_WIDTH-1:0] walk_rsp_epoch;
    logic                   layer_done;
    logic                   busy;
    logic [15:0]            stale_rsp_count;
    logic                   protocol_err;

    int errors = 0;
    int checks = 0;
    int nfires;
    int rsp_sent;
    int dones;
    logic fire_now;

    layer_exec_controller #(.MAX_OUTSTANDING(8), .STALE_CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .active_config(active_config),
        .layer_start_pulse(layer_start_pulse), .request_flip(request_flip),
        .flip_ack(flip_ack), .core_safe_to_flip(core_safe_to_flip),
        .no_outstanding_active(no_outstanding_active), .walk_req_valid(walk_req_valid),
        .walk_req_ready(walk_req_ready), .walk_req_idx(walk_req_idx),
        .walk_req_epoch(walk_req_epoch), .walk_rsp_valid(walk_rsp_valid),
        .walk_rsp_epoch(walk_rsp_epoch), .layer_done(layer_done), .busy(busy),
        .stale_rsp_count(stale_rsp_count), .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [31:0] c, input logic [31:0] w, input logic [7:0] e);
        active_config.compute_cycles = c;
        active_config.pointer_walks  = w;
        active_config.epoch          = e;
    endtask

    initial begin
        rst_n = 1'b0; layer_start_pulse = 1'b0; request_flip = 1'b0;
        walk_req_ready = 1'b0; walk_rsp_valid = 1'b0; walk_rsp_epoch = 8'd0;
        set_cfg(32'd0, 32'd0, 8'd0);
        tick(); tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_safe", core_safe_to_flip, 1'b1);
        chk("rst_noout", no_outstanding_active, 1'b1);
        chk("rst_valid", walk_req_valid, 1'b0);
        chk("rst_idx", walk_req_idx, 32'd0);
        chk("rst_ack", flip_ack, 1'b0);
        chk("rst_stale", stale_rsp_count, 16'd0);
        chk("rst_perr", protocol_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // Basic layer: C=3, W=0
        request_flip = 1'b1;
        tick();
        chk("b_ack", flip_ack, 1'b1);
        chk("b_safe", core_safe_to_flip, 1'b0);
        request_flip = 1'b0;
        set_cfg(32'd3, 32'd0, 8'd5);
        layer_start_pulse = 1'b1;
        tick();
        layer_start_pulse = 1'b0;
        chk("b_ack_1cyc", flip_ack, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b_nodone", layer_done, 1'b0);
            chk("b_busy", busy, 1'b1);
        end
        tick();
        chk("b_done", layer_done, 1'b1);
        chk("b_idle", busy, 1'b0);
        tick();
        chk("b_done_1cyc", layer_done, 1'b0);

        // Credit limit: C=0, W=20, 8 credits
        request_flip = 1'b1;
        tick();
        chk("c_ack", flip_ack, 1'b1);
        request_flip = 1'b0;
        set_cfg(32'd0, 32'd20, 8'd6);
        layer_start_pulse = 1'b1;
        walk_req_ready = 1'b1;
        tick();
        layer_start_pulse = 1'b0;
        chk("c_epoch", walk_req_epoch, 8'd6);
        nfires = 0;
        for (int i = 0; i < 12; i++) begin
            if (walk_req_valid) begin
                chk("c_idx", walk_req_idx, 32'(nfires));
                nfires++;
            end
            tick();
        end
        chk("c_fires8", nfires, 8);
        chk("c_valid_low", walk_req_valid, 1'b0);
        chk("c_noout", no_outstanding_active, 1'b0);
        rsp_sent = 0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            fire_now = walk_req_valid && walk_req_ready;
            if (fire_now) chk("c_idx2", walk_req_idx, 32'(nfires));
            if (rsp_sent < nfires) begin
                walk_rsp_valid = 1'b1; walk_rsp_epoch = 8'd6; rsp_sent++;
            end else begin
                walk_rsp_valid = 1'b0;
            end
            if (fire_now) nfires++;
            tick();
            if (layer_done) dones++;
        end
        walk_rsp_valid = 1'b0;
        chk("c_fires20", nfires, 20);
        chk("c_dones", dones, 1);
        chk("c_idle", busy, 1'b0);
        chk("c_noout_end", no_outstanding_active, 1'b1);
        chk("c_stale0", stale_rsp_count, 16'd0);
        chk("c_perr0", protocol_err, 1'b0);

        // Stale responses and protocol errors in IDLE (E=6)
        walk_rsp_valid = 1'b1; walk_rsp_epoch = 8'd1;
        tick();
        chk("s_stale1", stale_rsp_count, 16'd1);
        chk("s_perr0", protocol_err, 1'b0);
        walk_rsp_epoch = 8'd6;
        tick();
        walk_rsp_valid = 1'b0;
        chk("s_perr1", protocol_err, 1'b1);
        chk("s_idle1", busy, 1'b0);
        layer_start_pulse = 1'b1;
        tick();
        layer_start_pulse = 1'b0;
        chk("s_idle2", busy, 1'b0);
        chk("s_perr_sticky", protocol_err, 1'b1);

        // Backpressure, simultaneous fire+response, flip held throughout
        request_flip = 1'b1;
        walk_req_ready = 1'b0;
        tick();
        chk("p_ack", flip_ack, 1'b1);
        set_cfg(32'd0, 32'd3, 8'd7);
        layer_start_pulse = 1'b1;
        tick();
        layer_start_pulse = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("p_hold_valid", walk_req_valid, 1'b1);
            chk("p_hold_idx", walk_req_idx, 32'd0);
            chk("p_hold_epoch", walk_req_epoch, 8'd7);
            chk("p_noack", flip_ack, 1'b0);
            tick();
        end
        walk_req_ready = 1'b1;
        tick();
        chk("p_idx1", walk_req_idx, 32'd1);
        chk("p_out1", no_outstanding_active, 1'b0);
        walk_rsp_valid = 1'b1; walk_rsp_epoch = 8'd7;
        tick();
        chk("p_idx2", walk_req_idx, 32'd2);
        chk("p_simul_out", no_outstanding_active, 1'b0);
        walk_req_ready = 1'b0;
        tick();
        chk("p_out0", no_outstanding_active, 1'b1);
        chk("p_valid_idx2", walk_req_valid, 1'b1);
        chk("p_idx2_hold", walk_req_idx, 32'd2);
        walk_rsp_valid = 1'b0;
        walk_req_ready = 1'b1;
        tick();
        chk("p_drain_valid", walk_req_valid, 1'b0);
        chk("p_drain_busy", busy, 1'b1);
        chk("p_drain_noack", flip_ack, 1'b0);
        walk_rsp_valid = 1'b1;
        tick();
        walk_rsp_valid = 1'b0;
        chk("p_done", layer_done, 1'b1);
        chk("p_idle", busy, 1'b0);
        chk("p_noack_done", flip_ack, 1'b0);
        tick();
        chk("p_ack2", flip_ack, 1'b1);
        tick();
        chk("p_ack2_1cyc", flip_ack, 1'b0);

        // Flip held during COMPUTE (currently ARMED)
        set_cfg(32'd2, 32'd0, 8'd8);
        layer_start_pulse = 1'b1;
        tick();
        layer_start_pulse = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("f_noack", flip_ack, 1'b0);
            chk("f_busy", busy, 1'b1);
            tick();
        end
        chk("f_done", layer_done, 1'b1);
        chk("f_noack_done", flip_ack, 1'b0);
        tick();
        chk("f_ack", flip_ack, 1'b1);
        request_flip = 1'b0;
        tick();
        chk("f_ack_1cyc", flip_ack, 1'b0);

        // Reset mid-WALK with 3 outstanding (currently ARMED)
        set_cfg(32'd0, 32'd10, 8'd9);
        layer_start_pulse = 1'b1;
        walk_req_ready = 1'b1;
        tick();
        layer_start_pulse = 1'b0;
        tick(); tick(); tick();
        chk("r_idx3", walk_req_idx, 32'd3);
        chk("r_out", no_outstanding_active, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_valid", walk_req_valid, 1'b0);
        chk("r_idx", walk_req_idx, 32'd0);
        chk("r_epoch", walk_req_epoch, 8'd0);
        chk("r_busy", busy, 1'b0);
        chk("r_safe", core_safe_to_flip, 1'b1);
        chk("r_noout", no_outstanding_active, 1'b1);
        chk("r_stale", stale_rsp_count, 16'd0);
        chk("r_perr", protocol_err, 1'b0);
        tick();
        rst_n = 1'b1;
        walk_req_ready = 1'b0;
        walk_rsp_valid = 1'b1; walk_rsp_epoch = 8'd9;
        tick(); tick(); tick();
        walk_rsp_valid = 1'b0;
        chk("r_late_stale", stale_rsp_count, 16'd3);
        chk("r_late_perr", protocol_err, 1'b0);
        chk("r_late_idle", busy, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_exec_controller.md
Name: layer_exec_controller

Overview:
- Executes one layer at a time from `active_config`, directly downstream of the config manager, which produces `active_config` and `layer_start_pulse` and consumes `request_flip`/`flip_ack`.
- Runs the compute phase, then issues pointer-walk requests under credit control, then drains their responses.
- Drives the flip-safety handshake back to the config manager, so a flip only happens when the core is idle and no pointer walk is in flight.

Parameters:
- MAX_OUTSTANDING, 8, max in-flight pointer-walk requests (power of 2, 2..64).
- STALE_CNT_WIDTH, 16, width of the stale-response counter (saturating).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- active_config  in  layer_config_t  live layer config (flexpipe_pkg). Fields used: compute_cycles and pointer_walks (32-bit unsigned), epoch.
- layer_start_pulse  in  1  one-cycle pulse: new active_config is valid.
- request_flip  in  1  config manager wants to flip shadow to active.
- flip_ack  out  1  one-cycle grant of a flip.
- core_safe_to_flip  out  1  core is idle.
- no_outstanding_active  out  1  zero pointer walks in flight.
- walk_req_valid  out  1  pointer-walk request valid.
- walk_req_ready  in  1  downstream accepts the request.
- walk_req_idx  out  32  walk index, 0..pointer_walks-1.
- walk_req_epoch  out  EPOCH_WIDTH  epoch tag of the request.
- walk_rsp_valid  in  1  walk response (always accepted).
- walk_rsp_epoch  in  EPOCH_WIDTH  epoch tag of the response.
- layer_done  out  1  one-cycle pulse: layer complete.
- busy  out  1  state != IDLE.
- stale_rsp_count  out  STALE_CNT_WIDTH  responses whose epoch mismatched, saturating.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all counters 0.
  - flip_ack=0, layer_done=0, walk_req_valid=0, walk_req_idx=0, walk_req_epoch=0, stale_rsp_count=0, protocol_err=0.
  - core_safe_to_flip=1, no_outstanding_active=1, busy=0.
  - Reset mid-layer abandons the layer; responses arriving after reset are counted as stale.
- States: IDLE, ARMED, COMPUTE, WALK, DRAIN.
- IDLE:
  - core_safe_to_flip=1 (combinational on state).
  - If request_flip=1, flip_ack=0 and outstanding=0: register flip_ack=1 for exactly one cycle; go to ARMED.
  - flip_ack is never high two consecutive cycles.
- ARMED:
  - Wait for layer_start_pulse.
  - On the pulse, latch C=compute_cycles, W=pointer_walks, E=epoch.
  - Next state: COMPUTE if C>0, else WALK if W>0, else DRAIN.
- COMPUTE:
  - Down-counter loaded with C; decrements once per cycle.
  - State is held for exactly C cycles.
  - At count==1, go to WALK if W>0, else DRAIN.
- WALK:
  - walk_req_valid = (issued<W) && (outstanding<MAX_OUTSTANDING).
  - walk_req_idx=issued; walk_req_epoch=E.
  - Fire = valid && ready: issued+1, outstanding+1.
  - valid, idx and epoch stay stable until fire.
  - When the fire makes issued==W, go to DRAIN next cycle.
- DRAIN:
  - When outstanding==0 (after this cycle's update): layer_done=1 for one cycle, state becomes IDLE on the same edge.
- Responses (any state):
  - If walk_rsp_epoch==E and outstanding>0: outstanding-1.
  - Otherwise: stale_rsp_count+1, saturating at all-ones.
  - A fire and a matching response in the same cycle leave outstanding unchanged.
  - outstanding never exceeds MAX_OUTSTANDING and never goes below 0.
- no_outstanding_active = (outstanding==0), combinational.
- protocol_err is set (sticky until reset) on:
  - layer_start_pulse outside ARMED; the pulse is otherwise ignored.
  - A matching-epoch response while outstanding==0.
- Counter arithmetic: issued and the compute counter are 32-bit; pointer_walks=0xFFFFFFFF must not wrap.

Test Plan:
- Basic layer:
  - Stimulus: request_flip in IDLE, then layer_start with C=3, W=0.
  - Response: flip_ack one cycle; exactly 3 COMPUTE cycles; layer_done 1 cycle after entering DRAIN; busy low after.
- Credit limit:
  - Stimulus: C=0, W=20, MAX=8, ready=1, no responses.
  - Response: exactly 8 fires; valid then low; no_outstanding_active=0.
  - Then return 20 responses: all 20 issue, layer_done once, idx 0..19 in order.
- Backpressure and simultaneous events:
  - Stimulus: ready toggled 1/0 with a response in the same cycle as a fire.
  - Response: idx/epoch stable while stalled; outstanding unchanged in the simultaneous cycle.
- Stale responses and errors:
  - Stimulus: response with epoch≠E, then a matching response with outstanding=0, then layer_start in IDLE.
  - Response: stale_rsp_count=1; protocol_err=1; state unchanged.
- Flip gating:
  - Stimulus: request_flip held during COMPUTE and with outstanding=2 in IDLE.
  - Response: no flip_ack until IDLE with outstanding=0, then a single one-cycle ack.
- Reset mid-WALK:
  - Stimulus: assert rst_n=0 asynchronously with 3 outstanding.
  - Response: all outputs at reset values immediately; late responses increment stale_rsp_count.
